// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the program ROM and hands
// instructions to decode over valid/ready. Optional early jmp: FETCH_EARLY_JMP_EN.
module fetch_unit #(
  parameter logic [3:0] RESET_PC = 4'h0,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [3:0]       rom_addr,
  input  logic [15:0]      rom_inst,
  output logic [15:0]      inst_out,
  output logic [3:0]       pc_out,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             redirect_valid,
  input  logic [3:0]       redirect_target,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

  typedef struct packed {
    logic [15:0] inst;
    logic [3:0]  pc;
  } slot_t;

  state_t          state, state_nxt;
  slot_t           slot;
  logic [3:0]      pc;
  logic            vld;
  logic [CNT_W-1:0] cnt;
  logic            slot_free, capture, take_redir, is_jmp;

  assign rom_addr   = pc;
  assign inst_out   = slot.inst;
  assign pc_out     = slot.pc;
  assign inst_valid = vld;
  assign fetch_cnt  = cnt;
  assign slot_free  = !vld || inst_ready;

`ifdef FETCH_EARLY_JMP_EN
  assign is_jmp = (rom_inst[15:12] == 4'b1000);
`else
  assign is_jmp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;

  // Redirect beats everything; in BOOT it only seeds the PC.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    take_redir = 1'b0;
    case (state)
      BOOT: begin
        take_redir = redirect_valid;
        state_nxt  = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          take_redir = 1'b1;
          state_nxt  = FLUSH;
        end else if (slot_free) begin
          capture = 1'b1;
        end else begin
          state_nxt = STALL;
        end
      end
      STALL: begin
        if (redirect_valid) begin
          take_redir = 1'b1;
          state_nxt  = FLUSH;
        end else if (inst_ready) begin
          capture   = 1'b1;
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        if (redirect_valid) begin
          take_redir = 1'b1;
        end else begin
          capture   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      slot <= '0;
      vld  <= 1'b0;
      cnt  <= '0;
    end else begin
      // A handover in a redirect cycle still counts even though the slot clears.
      if (vld && inst_ready && (cnt != '1)) cnt <= cnt + CNT_W'(1);
      if (take_redir) begin
        pc  <= redirect_target;
        vld <= 1'b0;
      end else if (capture) begin
        if (is_jmp) begin
          pc  <= rom_inst[11:8];
          vld <= 1'b0;
        end else begin
          slot <= '{inst: rom_inst, pc: pc};
          vld  <= 1'b1;
          pc   <= pc + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle vector table, program-order scoreboard, and
// hand sequences for jmp, reset and boot-redirect corners.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rom_addr, sat_addr;
  logic [15:0] rom_inst, sat_inst;
  logic [15:0] inst_out, sat_io;
  logic [3:0]  pc_out, sat_pc;
  logic        inst_valid, sat_vld;
  logic        inst_ready, redirect_valid;
  logic [3:0]  redirect_target;
  logic [7:0]  fetch_cnt;
  logic [1:0]  sat_cnt;

  logic [15:0] rom [16];
  assign rom_inst = rom[rom_addr];
  assign sat_inst = rom[sat_addr];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(4'h0), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_cnt(fetch_cnt));

  fetch_unit #(.RESET_PC(4'h0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .rom_addr(sat_addr), .rom_inst(sat_inst),
    .inst_out(sat_io), .pc_out(sat_pc), .inst_valid(sat_vld),
    .inst_ready(inst_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_cnt(sat_cnt));

  typedef struct {
    logic        rdy, rv;
    logic [3:0]  tgt;
    logic        ev;
    logic [15:0] ei;
    logic [3:0]  ep, ea;
  } vec_t;

  typedef struct {
    logic [15:0] inst;
    logic [3:0]  pc;
  } exp_t;

  vec_t tbl [18];
  exp_t sb_q [$];
  int   tests = 0, fails = 0;
  int   m_cnt = 0;
  bit   sb_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic rdy, logic rv, logic [3:0] tgt, logic ev,
                              logic [15:0] ei, logic [3:0] ep, logic [3:0] ea);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.tgt = tgt; v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea;
    return v;
  endfunction

  // One clock: handovers are judged on the pre-edge outputs, counts after the edge.
  task automatic step();
    bit   hs;
    exp_t e;
    int   sat_exp;
    hs = inst_valid && inst_ready;
    if (hs && sb_on) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_handover", {16'h0, inst_out}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("sb_inst", {16'h0, inst_out}, {16'h0, e.inst});
        chk("sb_pc", {28'h0, pc_out}, {28'h0, e.pc});
      end
    end
    @(posedge clk); #1;
    if (hs && m_cnt < 255) m_cnt++;
    sat_exp = (m_cnt > 3) ? 3 : m_cnt;
    chk("fetch_cnt", {24'h0, fetch_cnt}, m_cnt);
    chk("sat_cnt", {30'h0, sat_cnt}, sat_exp);
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [15:0] ei,
                         input logic [3:0] ep, input logic [3:0] ea);
    chk({name, "_valid"}, {31'h0, inst_valid}, {31'h0, ev});
    chk({name, "_addr"}, {28'h0, rom_addr}, {28'h0, ea});
    if (ev) begin
      chk({name, "_inst"}, {16'h0, inst_out}, {16'h0, ei});
      chk({name, "_pc"}, {28'h0, pc_out}, {28'h0, ep});
    end
  endtask

  initial begin
    logic [3:0] wpc;
    int         budget;
    for (int i = 0; i < 16; i++) rom[i] = {4'h2, 4'(i), 4'(i), 4'(i)};
    rom[0] = 16'h1E07; rom[1] = 16'hBE01; rom[2] = 16'hCA00; rom[3] = 16'hFE00;
    rom[4] = 16'h8100; rom[10] = 16'hF200; rom[12] = 16'h8C00;

    tbl[0]  = mk(1, 0, 0,  0, 16'h0,   0,  0);
    tbl[1]  = mk(1, 0, 0,  1, 16'h1E07, 0, 1);
    tbl[2]  = mk(1, 0, 0,  1, 16'hBE01, 1, 2);
    tbl[3]  = mk(0, 0, 0,  1, 16'hBE01, 1, 2);
    tbl[4]  = mk(0, 0, 0,  1, 16'hBE01, 1, 2);
    tbl[5]  = mk(0, 0, 0,  1, 16'hBE01, 1, 2);
    tbl[6]  = mk(1, 0, 0,  1, 16'hCA00, 2, 3);
    tbl[7]  = mk(1, 1, 10, 0, 16'h0,   0,  10);
    tbl[8]  = mk(1, 0, 0,  1, 16'hF200, 10, 11);
    tbl[9]  = mk(0, 0, 0,  1, 16'hF200, 10, 11);
    tbl[10] = mk(0, 1, 15, 0, 16'h0,   0,  15);
    tbl[11] = mk(1, 1, 13, 0, 16'h0,   0,  13);
    tbl[12] = mk(1, 1, 15, 0, 16'h0,   0,  15);
    tbl[13] = mk(1, 0, 0,  1, 16'h2FFF, 15, 0);
    tbl[14] = mk(1, 0, 0,  1, 16'h1E07, 0, 1);
    tbl[15] = mk(1, 1, 0,  0, 16'h0,   0,  0);
    tbl[16] = mk(0, 0, 0,  1, 16'h1E07, 0, 1);
    tbl[17] = mk(1, 0, 0,  1, 16'hBE01, 1, 2);

    rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    chk_out("reset", 1'b0, 16'h0, 4'h0, 4'h0);
    chk("reset_inst", {16'h0, inst_out}, 32'h0);
    chk("reset_pc", {28'h0, pc_out}, 32'h0);
    chk("reset_cnt", {24'h0, fetch_cnt}, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      inst_ready = tbl[i].rdy; redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].ea);
    end

    // Scoreboard: after redirecting to 3, handovers must follow program order.
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 4'd3;
    step();
    chk_out("sb_redir", 1'b0, 16'h0, 4'h0, 4'd3);
    redirect_valid = 1'b0;
    wpc = 4'd3;
    while (sb_q.size() < 20) begin
`ifdef FETCH_EARLY_JMP_EN
      if (rom[wpc][15:12] == 4'b1000) begin
        wpc = rom[wpc][11:8];
        continue;
      end
`endif
      sb_q.push_back('{inst: rom[wpc], pc: wpc});
      wpc = wpc + 4'd1;
    end
    sb_on = 1;
    budget = 0;
    while (sb_q.size() != 0 && budget < 400) begin
      inst_ready = 1'($urandom_range(0, 1));
      step();
      budget++;
    end
    chk("sb_drained", sb_q.size(), 0);
    sb_on = 0;

    // jmp at 12 targets itself.
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 4'd12;
    step();
    chk_out("jmp_redir", 1'b0, 16'h0, 4'h0, 4'd12);
    redirect_valid = 1'b0;
    step();
`ifdef FETCH_EARLY_JMP_EN
    chk_out("jmp_loop0", 1'b0, 16'h0, 4'h0, 4'd12);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("jmp_loop%0d", i + 1), 1'b0, 16'h0, 4'h0, 4'd12);
    end
    redirect_valid = 1'b1; redirect_target = 4'd10;
    step();
    chk_out("jmp_escape", 1'b0, 16'h0, 4'h0, 4'd10);
    redirect_valid = 1'b0;
    step();
    chk_out("jmp_escape_tgt", 1'b1, 16'hF200, 4'd10, 4'd11);
`else
    chk_out("jmp_present", 1'b1, 16'h8C00, 4'd12, 4'd13);
    step();
    chk_out("jmp_next", 1'b1, 16'h2DDD, 4'd13, 4'd14);
`endif

    // Reset mid-stall clears outputs without a clock edge.
    inst_ready = 1'b0;
    step(); step();
    chk("stall_valid", {31'h0, inst_valid}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 16'h0, 4'h0, 4'h0);
    chk("async_rst_inst", {16'h0, inst_out}, 32'h0);
    chk("async_rst_pc", {28'h0, pc_out}, 32'h0);
    chk("async_rst_cnt", {24'h0, fetch_cnt}, 32'h0);
    m_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    inst_ready = 1'b1;
    step(); chk_out("refill1", 1'b0, 16'h0, 4'h0, 4'h0);
    step(); chk_out("refill2", 1'b1, 16'h1E07, 4'h0, 4'h1);
    step(); chk_out("refill3", 1'b1, 16'hBE01, 4'h1, 4'h2);

    // Redirect while in BOOT seeds the PC and goes straight to fetch.
    #1 rst_n = 1'b0;
    #1 m_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    redirect_valid = 1'b1; redirect_target = 4'd10;
    step(); chk_out("boot_redir", 1'b0, 16'h0, 4'h0, 4'd10);
    redirect_valid = 1'b0;
    step(); chk_out("boot_redir_tgt", 1'b1, 16'hF200, 4'd10, 4'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
